uart_mmio_tx: RTL and testbench
===============================

# uart_mmio_tx

Memory-mapped UART transmitter that the core drives through its MMIO write path (`mmio_wea` and `mmio_dat`). Bytes written by the Memory stage are queued in a small FIFO and serialized onto `tx` as 8N1 frames, LSB first. A ready flag (`mmio_read`) returns to the core for software polling. A one-cycle drain interrupt can be ORed into the core's trap request.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range is 2 or more.
- `FIFO_DEPTH`, default 16: number of queued bytes. Must be a power of 2, 2 or more.
- `clk`  in  1: system clock.
- `Rst`  in  1: reset, synchronous and active-high.
- `mmio_wea`  in  1: write strobe, one byte per asserted cycle.
- `mmio_dat`  in  32: write data. Only `[7:0]` is transmitted; `[31:8]` is ignored.
- `tx`  out  1: serial output, idle high.
- `mmio_read`  out  1: 1 when the FIFO is not full, so a write this cycle will be accepted.
- `tx_busy`  out  1: 1 while the shifter is not in IDLE, or the FIFO is non-empty.
- `fifo_count`  out  `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `ovf`  out  1: sticky flag set by a dropped write. Cleared only by `Rst`.
- `tx_irq`  out  1: one-cycle pulse when the transmitter fully drains.

## Operation
- **FIFO:** circular buffer with read/write pointers that wrap modulo `FIFO_DEPTH`, plus a separate count register.
- **Write acceptance:** a write is accepted when `mmio_wea` is high and (count < `FIFO_DEPTH`, or a pop occurs in the same cycle).
  - A write while full with no pop is dropped and sets `ovf`.
  - A simultaneous push and pop leaves the count unchanged.
- **Shifter states:** IDLE, START, DATA, STOP (plus PARITY when the parity feature is enabled).
  - IDLE: `tx`=1. If count>0, pop the head byte into the shift register, clear the baud counter, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=`shreg[idx]` for `CLKS_PER_BIT` cycles. Increment idx. After idx 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end:
    - if count>0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE and pulse `tx_irq`.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1. A bit boundary occurs on terminal count, and the counter wraps to 0.
- **`tx` drive:** `tx` is registered, taken directly from a flop, with no combinational glitch path.

## Timing
- **Reset values:** `tx`=1, `mmio_read`=1, `tx_busy`=0, `fifo_count`=0, `ovf`=0, `tx_irq`=0. State is IDLE and the FIFO pointers are 0.
- **Reset mid-frame:** the frame is aborted, the FIFO is flushed, and `tx`=1 on the cycle after the `Rst` edge.
- **Write latency:** a write sampled at edge N into an empty, idle block gives `fifo_count`=1 after edge N. The pop happens at edge N+1, and `tx` falls after edge N+2.
- **Bit and frame length:** each bit is exactly `CLKS_PER_BIT` cycles. A frame is 10×`CLKS_PER_BIT` cycles (11× with parity).
- **Back-to-back frames:** frames from a continuously non-empty FIFO are contiguous, with no gap between them.
- **`mmio_read`:** updates the cycle after the count changes. It is 0 exactly while count==`FIFO_DEPTH`.
- **`tx_irq`:** high for exactly one cycle, the cycle after the final stop-bit edge. `tx_busy` falls in that same cycle.
- **Write on the final stop edge:** a write arriving on the same edge that ends the final stop bit is accepted into the FIFO. The next frame then starts one cycle later, and `tx_irq` still pulses.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - a PARITY state is inserted between DATA and STOP;
  - it drives even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles;
  - the frame becomes 8E1 (11 bits).
- **Not defined:** the PARITY state and its logic are absent, and the frame is 8N1 (10 bits).

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Single byte:** reset, then write 0x55 once. `tx` is 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles. `tx_irq` pulses once, 40 cycles after `tx` falls.
- **Back-to-back:** write 0xA3 then 0x0F on consecutive cycles. Two frames are contiguous (80 cycles, no idle gap), with a single `tx_irq` at the end.
- **Overflow:** write 6 bytes on consecutive cycles while the first frame starts.
  - Expected: bytes 1–5 accepted (one popped immediately), byte 6 dropped.
  - `ovf`=1 and `mmio_read`=0 while the count is 4.
  - Only 5 frames are transmitted.
- **Push and pop while full:** with the FIFO full, write on the cycle STOP ends. The write is accepted, the count stays 4, and `ovf` stays 0.
- **Reset mid-frame:** assert `Rst` during DATA bit 3 of 0x00. `tx`=1 the next cycle, `fifo_count`=0, and no `tx_irq` pulse occurs.
- **Parity (`UART_TX_PARITY_EN`):** write 0x07. The parity bit is 1 and the frame is 44 cycles long.

Source files
------------

// File: rtl/uart_mmio_tx.sv
// uart_mmio_tx: MMIO-fed UART transmitter, FIFO-buffered 8N1 framing, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_mmio_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          Rst,
  input  logic                          mmio_wea,
  input  logic [31:0]                   mmio_dat,
  output logic                          tx,
  output logic                          mmio_read,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf,
  output logic                          tx_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_STOP;
`endif
  state_t r_state, w_next;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_idx;
  logic [7:0]    r_shreg;
  logic          r_tx, r_ovf, r_irq;
  logic          w_tick, w_empty, w_pop, w_push, w_done, w_tx_d, w_unused;
  assign w_unused  = ^mmio_dat[31:8];
  assign w_tick    = r_baud == LAST;
  assign w_empty   = r_count == '0;
  // Pop either from idle or exactly at the end of a stop bit, so queued frames run back to back
  assign w_pop     = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_tick));
  assign w_push    = mmio_wea && (r_count != FULL || w_pop);
  assign tx        = r_tx;
  assign tx_irq    = r_irq;
  assign ovf       = r_ovf;
  assign fifo_count = r_count;
  assign mmio_read = r_count != FULL;
  assign tx_busy   = r_state != S_IDLE || !w_empty;
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:   if (!w_empty) w_next = S_START;
      S_START:  if (w_tick) w_next = S_DATA;
      S_DATA:   if (w_tick && r_idx == 3'd7) w_next = S_AFTER_DATA;
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_tick) w_next = S_STOP;
`endif
      S_STOP:   if (w_tick) begin
        w_next = w_empty ? S_IDLE : S_START;
        w_done = w_empty;
      end
      default:  w_next = S_IDLE;
    endcase
  end
`ifdef UART_TX_PARITY_EN
  assign w_tx_d = r_state == S_START ? 1'b0 : r_state == S_DATA ? r_shreg[r_idx] :
                  r_state == S_PARITY ? ^r_shreg : 1'b1;
`else
  assign w_tx_d = r_state == S_START ? 1'b0 : r_state == S_DATA ? r_shreg[r_idx] : 1'b1;
`endif
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= mmio_dat[7:0];
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
      r_ovf   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx_d;
      r_irq   <= w_done;
      r_baud  <= (r_state == S_IDLE || w_tick) ? '0 : r_baud + BW'(1);
      if (w_tick) r_idx <= r_state == S_DATA ? r_idx + 3'd1 : 3'd0;
      if (w_pop) begin
        r_shreg <= r_mem[r_rp];
        r_rp    <= r_rp + AW'(1);
      end
      if (w_push) r_wp <= r_wp + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (mmio_wea && !w_push) r_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_mmio_tx.sv
// tb_uart_mmio_tx: randomized and directed bench against a frame-level reference model.
module tb_uart_mmio_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;
  logic clk = 1'b0, rst = 1'b1, wea = 1'b0;
  logic [31:0] dat = '0;
  logic tx, mread, busy, ovf, irq;
  logic [2:0] cnt;
  int checks = 0, failures = 0;
  uart_mmio_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .Rst(rst), .mmio_wea(wea), .mmio_dat(dat), .tx(tx),
    .mmio_read(mread), .tx_busy(busy), .fifo_count(cnt), .ovf(ovf), .tx_irq(irq)
  );
  always #5 clk = ~clk;
  // Model: queue of accepted bytes plus the edge at which the current frame started
  byte unsigned q[$];
  int k = 0, s = 0;
  bit act = 0, m_ovf = 0, m_irq = 0, m_tx = 1;
  logic [7:0] cur = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (NB == 11 && i == 9) return ^b;
    return 1'b1;
  endfunction
  task automatic step();
    int n;
    bit pop;
    @(posedge clk);
    k++;
    if (rst) begin
      q.delete();
      act = 0; m_ovf = 0; m_irq = 0; m_tx = 1;
    end else begin
      pop = 0;
      n = q.size();
      m_tx = act ? frame_bit(cur, (k - 1 - s) / CPB) : 1'b1;
      m_irq = 0;
      if (act && k == s + FL) begin
        if (n > 0) pop = 1;
        else begin act = 0; m_irq = 1; end
      end else if (!act && n > 0) pop = 1;
      if (pop) begin cur = q.pop_front(); s = k; act = 1; end
      if (wea && (n < DEPTH || pop)) q.push_back(dat[7:0]);
      else if (wea) m_ovf = 1;
    end
    @(negedge clk);
    check("tx", 32'(tx), 32'(m_tx));
    check("tx_irq", 32'(irq), 32'(m_irq));
    check("fifo_count", 32'(cnt), q.size());
    check("mmio_read", 32'(mread), 32'(q.size() < DEPTH));
    check("tx_busy", 32'(busy), 32'(act || q.size() > 0));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask
  task automatic cyc(input bit w, input logic [31:0] d, input bit r);
    wea = w; dat = d; rst = r;
    step();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, 0);
  endtask
  initial begin
    int rate;
    cyc(0, 0, 1); cyc(0, 0, 1);
    // single byte
    cyc(1, 32'hFFFF_FF55, 0);
    idle(60);
    // back-to-back
    cyc(1, 32'hA3, 0); cyc(1, 32'h0F, 0);
    idle(100);
    // overflow burst of six
    for (int i = 0; i < 6; i++) cyc(1, 32'h10 + i, 0);
    idle(5 * FL + 20);
    // push and pop while full, write landing on the stop-ending edge
    cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 32'h20 + i, 0);
    for (int i = 0; i < 100 && !(act && k + 1 == s + FL); i++) cyc(0, 0, 0);
    cyc(1, 32'hC6, 0);
    idle(5 * FL + 20);
    // reset during data bit 3 of 0x00
    cyc(0, 0, 1);
    cyc(1, 32'h00, 0);
    for (int i = 0; i < 100 && !(act && k == s + 4 * CPB + 1); i++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    idle(60);
    // randomized traffic with varying write rates and occasional reset
    for (int c = 0; c < 8; c++) begin
      rate = c % 4 == 0 ? 0 : c % 4 == 1 ? 5 : c % 4 == 2 ? 30 : 90;
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(99) < rate, $urandom, $urandom_range(399) == 0);
    end
    idle(6 * FL);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
